// File: rtl/shifter_pkg.sv
// Shared types for the multi-cycle shifter: shift-mode encoding and control FSM states.
package shifter_pkg;

  typedef enum logic [2:0] {
    SLL = 3'b000,
    SRL = 3'b001,
    SRA = 3'b010,
    ROL = 3'b011,
    ROR = 3'b100
  } shift_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One iteration of the shifter: applies a shift/rotate of i_s bits (0..STEP) to i_data.
module shift_step
  import shifter_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int STEP = 1,
  localparam int SW   = $clog2(STEP + 1)
) (
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_data,
  input  logic [SW-1:0]   i_s,
  output logic [XLEN-1:0] o_data
);

  logic [2*XLEN-1:0] w_dbl_l;
  logic [2*XLEN-1:0] w_dbl_r;

  // Rotates use a doubled operand so bits leaving one end re-enter at the other.
  always_comb begin
    w_dbl_l = {i_data, i_data} << i_s;
    w_dbl_r = {i_data, i_data} >> i_s;
    o_data  = i_data;
    case (i_op)
      SLL:     o_data = i_data << i_s;
      SRL:     o_data = i_data >> i_s;
      SRA:     o_data = $unsigned($signed(i_data) >>> i_s);
      ROL:     o_data = w_dbl_l[2*XLEN-1:XLEN];
      ROR:     o_data = w_dbl_r[XLEN-1:0];
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/multi_mode_shifter.sv
// Sequential shifter: captures an operand with start, shifts it up to STEP bits per
// cycle in the selected mode, and pulses done for one cycle when the result is ready.
module multi_mode_shifter
  import shifter_pkg::*;
#(
  parameter  int XLEN = 32,
  parameter  int STEP = 1,
  localparam int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] data_in,
  input  logic [SHW-1:0]  amount,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] data_out
);

  localparam int             SW       = $clog2(STEP + 1);
  localparam logic [SHW-1:0] STEP_AMT = SHW'(STEP);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [2:0]        r_op;
  logic [SHW-1:0]    r_rem;
  logic [XLEN-1:0]   r_data;
  logic              r_ready;
  logic              r_busy;
  logic              r_done;
  logic              w_accept;
  logic [SHW-1:0]    w_s_amt;
  logic [SW-1:0]     w_s;
  logic [XLEN-1:0]   w_step_data;

  assign w_accept = start & r_ready;
  assign w_s_amt  = (r_rem < STEP_AMT) ? r_rem : STEP_AMT;
  assign w_s      = w_s_amt[SW-1:0];

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP)
  ) u_shift_step (
    .i_op   (r_op),
    .i_data (r_data),
    .i_s    (w_s),
    .o_data (w_step_data)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state_nxt = (amount != {SHW{1'b0}}) ? SHIFT : DONE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SHIFT: begin
        if (r_rem == w_s_amt) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = SHIFT;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they change cleanly with the FSM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ready <= (w_state_nxt == IDLE) || (w_state_nxt == DONE);
      r_busy  <= (w_state_nxt == SHIFT);
      r_done  <= (w_state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= {XLEN{1'b0}};
      r_rem  <= {SHW{1'b0}};
      r_op   <= SLL;
    end else if (w_accept) begin
      r_data <= data_in;
      r_rem  <= amount;
      r_op   <= op;
    end else if (r_state == SHIFT) begin
      r_data <= w_step_data;
      r_rem  <= r_rem - w_s_amt;
    end
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign data_out = r_data;

endmodule

// File: tb/tb_multi_mode_shifter.sv
// Directed bench for multi_mode_shifter with one STEP=1 and one STEP=4 instance.
module tb_multi_mode_shifter;
  import shifter_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start1, start4;
  logic [2:0]  op;
  logic [31:0] din;
  logic [4:0]  amt;
  logic        rdy1, bsy1, dn1, rdy4, bsy4, dn4;
  logic [31:0] dout1, dout4;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  multi_mode_shifter #(.XLEN(32), .STEP(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .data_in(din), .amount(amt),
    .ready(rdy1), .busy(bsy1), .done(dn1), .data_out(dout1)
  );

  multi_mode_shifter #(.XLEN(32), .STEP(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .op(op), .data_in(din), .amount(amt),
    .ready(rdy4), .busy(bsy4), .done(dn4), .data_out(dout4)
  );

  task automatic launch(input bit sel, input logic [2:0] o, input logic [31:0] d, input logic [4:0] a);
    op = o; din = d; amt = a;
    if (sel) start4 = 1'b1; else start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0; start4 = 1'b0;
  endtask

  task automatic wait_done(input bit sel, output int nbusy, output bit got);
    nbusy = 0; got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if ((sel ? dn4 : dn1) === 1'b1) begin
        got = 1'b1;
        break;
      end
      if ((sel ? bsy4 : bsy1) === 1'b1) nbusy++;
      @(posedge clk); #1;
    end
  endtask

  task automatic run_op(input bit sel, input logic [2:0] o, input logic [31:0] d, input logic [4:0] a,
                        input logic [31:0] exp, input int exp_busy, input string name);
    int nb;
    bit got;
    logic [31:0] dv;
    launch(sel, o, d, a);
    wait_done(sel, nb, got);
    checks++;
    if (!got) begin errors++; $display("FAIL %s done: timed out waiting for done", name); end
    checks++;
    if (nb !== exp_busy) begin errors++; $display("FAIL %s busy_cycles: got %0d expected %0d", name, nb, exp_busy); end
    dv = sel ? dout4 : dout1;
    checks++;
    if (dv !== exp) begin errors++; $display("FAIL %s data_out: got %h expected %h", name, dv, exp); end
    @(posedge clk); #1;
    checks++;
    if ((sel ? dn4 : dn1) !== 1'b0 || (sel ? rdy4 : rdy1) !== 1'b1) begin
      errors++;
      $display("FAIL %s after_done: done=%b ready=%b expected done=0 ready=1", name,
               (sel ? dn4 : dn1), (sel ? rdy4 : rdy1));
    end
  endtask

  task automatic test_reset;
    checks++;
    if (dout1 !== 32'h0) begin errors++; $display("FAIL reset data_out1: got %h expected 00000000", dout1); end
    checks++;
    if ({rdy1, bsy1, dn1} !== 3'b100) begin errors++; $display("FAIL reset flags1: got %b expected 100", {rdy1, bsy1, dn1}); end
    checks++;
    if (dout4 !== 32'h0) begin errors++; $display("FAIL reset data_out4: got %h expected 00000000", dout4); end
    checks++;
    if ({rdy4, bsy4, dn4} !== 3'b100) begin errors++; $display("FAIL reset flags4: got %b expected 100", {rdy4, bsy4, dn4}); end
  endtask

  task automatic test_step1;
    run_op(1'b0, SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 31, "sll31");
    run_op(1'b0, SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 4,  "sra4");
    run_op(1'b0, SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 4,  "srl4");
    run_op(1'b0, ROR, 32'h1234_5678, 5'd8,  32'h7812_3456, 8,  "ror8");
    run_op(1'b0, ROL, 32'h8000_0001, 5'd1,  32'h0000_0003, 1,  "rol1");
    run_op(1'b0, 3'b101, 32'hA5A5_A5A5, 5'd3, 32'hA5A5_A5A5, 3, "reserved");
  endtask

  task automatic test_step4;
    run_op(1'b1, SLL, 32'h0000_0001, 5'd6, 32'h0000_0040, 2, "s4_sll6");
    run_op(1'b1, SRA, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 0, "s4_amt0");
    run_op(1'b1, ROR, 32'h1234_5678, 5'd8, 32'h7812_3456, 2, "s4_ror8");
    run_op(1'b1, SRA, 32'h8000_0000, 5'd5, 32'hFC00_0000, 2, "s4_sra5");
  endtask

  task automatic test_ignore_start;
    int nb;
    bit got;
    launch(1'b0, SLL, 32'h0000_0001, 5'd10);
    repeat (3) begin @(posedge clk); #1; end
    op = SRL; din = 32'hFFFF_FFFF; amt = 5'd2; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    wait_done(1'b0, nb, got);
    checks++;
    if (!got) begin errors++; $display("FAIL ignore done: timed out waiting for done"); end
    checks++;
    if (nb !== 6) begin errors++; $display("FAIL ignore busy_cycles: got %0d expected 6", nb); end
    checks++;
    if (dout1 !== 32'h0000_0400) begin errors++; $display("FAIL ignore data_out: got %h expected 00000400", dout1); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int nb;
    bit got;
    launch(1'b0, SLL, 32'h0000_0003, 5'd2);
    wait_done(1'b0, nb, got);
    checks++;
    if (!got || dout1 !== 32'h0000_000C) begin
      errors++; $display("FAIL b2b first: done=%b data_out=%h expected done=1 data_out=0000000c", got, dout1);
    end
    op = SRL; din = 32'h0000_00F0; amt = 5'd4; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    checks++;
    if (bsy1 !== 1'b1 || dn1 !== 1'b0) begin
      errors++; $display("FAIL b2b accept: busy=%b done=%b expected busy=1 done=0", bsy1, dn1);
    end
    wait_done(1'b0, nb, got);
    checks++;
    if (!got || nb !== 4) begin errors++; $display("FAIL b2b second: done=%b busy_cycles=%0d expected done=1 busy_cycles=4", got, nb); end
    checks++;
    if (dout1 !== 32'h0000_000F) begin errors++; $display("FAIL b2b data_out: got %h expected 0000000f", dout1); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_shift;
    bit seen;
    launch(1'b0, SLL, 32'h0000_0001, 5'd20);
    repeat (5) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (dout1 !== 32'h0) begin errors++; $display("FAIL midrst data_out: got %h expected 00000000", dout1); end
    checks++;
    if ({rdy1, bsy1, dn1} !== 3'b100) begin errors++; $display("FAIL midrst flags: got %b expected 100", {rdy1, bsy1, dn1}); end
    @(posedge clk); #1;
    reset = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (dn1 === 1'b1 || bsy1 === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen !== 1'b0 || dout1 !== 32'h0) begin
      errors++; $display("FAIL midrst after: activity=%b data_out=%h expected activity=0 data_out=00000000", seen, dout1);
    end
  endtask

  initial begin
    reset = 1'b1; start1 = 1'b0; start4 = 1'b0;
    op = 3'b000; din = 32'h0; amt = 5'd0;
    @(posedge clk); #1;
    test_reset;
    reset = 1'b0;
    @(posedge clk); #1;
    test_step1;
    test_step4;
    test_ignore_start;
    test_back_to_back;
    test_reset_mid_shift;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
